dlx_icache: RTL and testbench
=============================

Name: dlx_icache

Overview:
- Direct-mapped instruction cache; the responder side of the fetch-stage ic_addr/ic_data interface.
- On a hit, returns the addressed instruction word combinationally in the same cycle.
- On a miss, asserts ic_wait and refills the whole line from the main-memory read port through a small refill FSM.
- Sits between the IF pipe stage and the memory controller; ic_wait is ORed into the pipe stall at top level.

Parameters:
- NUM_LINES, 64, number of cache lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ic_addr  in  32 (dlx_addr)  fetch byte address from the IF stage.
- ic_data  out  32 (dlx_word)  instruction word; valid only when ic_wait=0.
- ic_wait  out  1  fetch not serviceable this cycle; IF must hold its PC.
- ic_flush  in  1  one-cycle pulse; invalidates all lines.
- mem_req  out  1  refill read request, held until mem_ack.
- mem_addr  out  32 (dlx_addr)  word-aligned refill read address.
- mem_ack  in  1  one-cycle read-complete strobe; mem_rdata is valid in that cycle.
- mem_rdata  in  32 (dlx_word)  refill read data.

Behaviour:
- Address split: off = ic_addr[1:0], ignored (treat as aligned). word = next log2(LINE_WORDS) bits. idx = next log2(NUM_LINES) bits. tag = remaining upper bits.
  - Defaults: word=[3:2], idx=[9:4], tag=[31:10].
- Storage:
  - valid[NUM_LINES] in flops, cleared by reset.
  - tag and data arrays in flops, not reset.
- hit = (state==IDLE) && valid[idx] && (tag_arr[idx]==tag).
- ic_data = data_arr[idx][word] when hit, else 32'h0.
- ic_wait = !hit. Combinational, same cycle as ic_addr.
- FSM states:
  - IDLE: on !hit, latch refill_tag/refill_idx from ic_addr, set wcnt=0, go to REFILL.
  - REFILL:
    - mem_req=1, mem_addr = {refill_tag, refill_idx, wcnt, 2'b00}.
    - On mem_ack: write mem_rdata into data_arr[refill_idx][wcnt], then wcnt++.
    - On the ack with wcnt==LINE_WORDS-1: write tag_arr[refill_idx]=refill_tag, set valid[refill_idx]=1, go to IDLE.
- Words are fetched in order 0..LINE_WORDS-1; no critical-word-first.
- mem_req deasserts in the cycle after the final ack (state is IDLE).
- Miss penalty: 1 cycle after a miss is detected, req is issued. With a memory acking in N cycles per word, the hit appears LINE_WORDS*N + 1 cycles after the miss cycle.
- ic_addr may change during REFILL:
  - the refill completes for the latched line;
  - the new address is looked up only on return to IDLE.
- ic_flush:
  - Clears all valid bits next edge in any state.
  - If asserted in the same cycle as the final refill ack, valid[refill_idx] stays 0 (flush wins).
  - If asserted earlier in a refill, the refill completes and validates its line.
  - Flush does not abort mem_req.
- mem_ack while in IDLE is ignored.
- Reset (async, any time including mid-refill):
  - state=IDLE, wcnt=0, all valid=0.
  - mem_req=0 and mem_addr=0 immediately.
  - ic_wait=1 and ic_data=0 (everything misses).
- wcnt wraps only via the FSM exit; never exceeds LINE_WORDS-1.

Decomposition:
- dlx_global_pkg:
  - IC_NUM_LINES and IC_LINE_WORDS defaults;
  - ic_state_t enum {IC_IDLE, IC_REFILL};
  - reuse dlx_word / dlx_addr.
- Address field-slicing helpers (functions) also live in the package.
- One natural sub-module, dlx_icache_refill: FSM, wcnt, mem_req/mem_addr generation, write enables.
- Arrays and hit logic stay in dlx_icache.

Test Plan:
- Reset released with ic_addr=0:
  - ic_wait=1, mem_req=1, mem_addr=0x0 one cycle later.
  - Memory acks words 0x11,0x22,0x33,0x44 with 1-cycle latency; then ic_data=0x11, ic_wait=0.
- After refill of line 0, ic_addr=0x4/0x8/0xC → ic_data=0x22/0x33/0x44 with ic_wait=0 in the same cycle.
- Conflict: fill line 0 via ic_addr=0x0, then ic_addr=0x400 (same idx, tag 1):
  - miss and refill from mem_addr 0x400..0x40C;
  - re-access 0x0 misses again.
- ic_addr changes 0x0→0x20 mid-refill:
  - refill continues at mem_addr 0x4,0x8,0xC;
  - then a new miss refills 0x20..0x2C.
- Flush:
  - ic_flush pulse after line 0 is valid → next access to 0x0 misses.
  - ic_flush coincident with the final ack → the line is still invalid afterwards.
- rst_n low during second refill word:
  - mem_req drops asynchronously; after release all lines miss.
  - Refill restarts at word 0 (mem_addr 0x0).

Source files
------------

// File: rtl/dlx_global_pkg.sv
// Shared DLX types plus instruction-cache defaults and address helpers.
//   dlx_word / dlx_addr : 32-bit data word and byte address
//   ic_state_t          : refill FSM state encoding
//   addr_field()        : extracts a bit field from a fetch address
package dlx_global_pkg;

  typedef logic [31:0] dlx_word;
  typedef logic [31:0] dlx_addr;

  localparam int unsigned IC_NUM_LINES  = 64;
  localparam int unsigned IC_LINE_WORDS = 4;

  typedef enum logic {IC_IDLE, IC_REFILL} ic_state_t;

  // Returns addr[lsb +: width] right-justified; callers size-cast the result.
  function automatic dlx_addr addr_field(dlx_addr addr, int unsigned lsb, int unsigned width);
    dlx_addr mask;
    mask = (dlx_addr'(1) << width) - dlx_addr'(1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/dlx_icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
//   ic_addr/ic_data/ic_wait/ic_flush : IF stage lookup and flush
//   mem_req/mem_addr/mem_ack/mem_rdata : refill read port
// slave  : the cache's view; master : the view of its surroundings.
interface dlx_icache_if;
  import dlx_global_pkg::*;

  dlx_addr ic_addr;
  dlx_word ic_data;
  logic    ic_wait;
  logic    ic_flush;
  logic    mem_req;
  dlx_addr mem_addr;
  logic    mem_ack;
  dlx_word mem_rdata;

  modport slave (
    input  ic_addr, ic_flush, mem_ack, mem_rdata,
    output ic_data, ic_wait, mem_req, mem_addr
  );

  modport master (
    output ic_addr, ic_flush, mem_ack, mem_rdata,
    input  ic_data, ic_wait, mem_req, mem_addr
  );
endinterface

// File: rtl/dlx_icache_refill.sv
// Line refill controller for dlx_icache.
//   clk, rst_n             : clock, async active-low reset
//   hit                    : lookup hit from the cache arrays
//   lookup_tag/lookup_idx  : fields of the current fetch address
//   mem_ack                : read-complete strobe
//   idle                   : FSM in IC_IDLE (lookups allowed)
//   mem_req/mem_addr       : refill read request and word address
//   refill_tag/refill_idx  : line being refilled
//   wcnt                   : word being refilled
//   data_we                : write mem_rdata into the data array
//   line_done              : final word written; install tag / valid
module dlx_icache_refill
  import dlx_global_pkg::*;
#(
  parameter int unsigned WORD_W = 2,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned TAG_W  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic [IDX_W-1:0]  lookup_idx,
  input  logic              mem_ack,
  output logic              idle,
  output logic              mem_req,
  output dlx_addr           mem_addr,
  output logic [TAG_W-1:0]  refill_tag,
  output logic [IDX_W-1:0]  refill_idx,
  output logic [WORD_W-1:0] wcnt,
  output logic              data_we,
  output logic              line_done
);

  localparam logic [WORD_W-1:0] LAST_WORD = '1;

  ic_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IC_IDLE;
      wcnt       <= '0;
      refill_tag <= '0;
      refill_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IC_IDLE && !hit) begin
        refill_tag <= lookup_tag;
        refill_idx <= lookup_idx;
        wcnt       <= '0;
      end else if (data_we) begin
        wcnt <= line_done ? '0 : wcnt + WORD_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idle      = (state_q == IC_IDLE);
    mem_req   = 1'b0;
    mem_addr  = '0;
    data_we   = 1'b0;
    line_done = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (!hit) state_d = IC_REFILL;
      end
      IC_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {refill_tag, refill_idx, wcnt, 2'b00};
        if (mem_ack) begin
          data_we = 1'b1;
          if (wcnt == LAST_WORD) begin
            line_done = 1'b1;
            state_d   = IC_IDLE;
          end
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

endmodule

// File: rtl/dlx_icache.sv
// Direct-mapped instruction cache answering the IF stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : dlx_icache_if.slave (fetch lookup + refill read port)
// A hit returns the word combinationally; a miss raises ic_wait and the
// refill controller fetches the whole line in word order.
module dlx_icache
  import dlx_global_pkg::*;
#(
  parameter int unsigned NUM_LINES  = IC_NUM_LINES,
  parameter int unsigned LINE_WORDS = IC_LINE_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  dlx_icache_if.slave  bus
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = 30 - WORD_W - IDX_W;

  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  assign word = WORD_W'(addr_field(bus.ic_addr, 2, WORD_W));
  assign idx  = IDX_W'(addr_field(bus.ic_addr, 2 + WORD_W, IDX_W));
  assign tag  = TAG_W'(addr_field(bus.ic_addr, 2 + WORD_W + IDX_W, TAG_W));

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  dlx_word              data_arr [NUM_LINES][LINE_WORDS];

  logic              idle, hit, data_we, line_done;
  logic [TAG_W-1:0]  refill_tag;
  logic [IDX_W-1:0]  refill_idx;
  logic [WORD_W-1:0] wcnt;

  dlx_icache_refill #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_refill (
    .clk        (clk),
    .rst_n      (rst_n),
    .hit        (hit),
    .lookup_tag (tag),
    .lookup_idx (idx),
    .mem_ack    (bus.mem_ack),
    .idle       (idle),
    .mem_req    (bus.mem_req),
    .mem_addr   (bus.mem_addr),
    .refill_tag (refill_tag),
    .refill_idx (refill_idx),
    .wcnt       (wcnt),
    .data_we    (data_we),
    .line_done  (line_done)
  );

  // Flush takes priority, so a flush on the final ack leaves the line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (bus.ic_flush) begin
      valid <= '0;
    end else if (line_done) begin
      valid[refill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_arr[refill_idx][wcnt] <= bus.mem_rdata;
    if (line_done) tag_arr[refill_idx] <= refill_tag;
  end

  assign hit         = idle && valid[idx] && (tag_arr[idx] == tag);
  assign bus.ic_wait = !hit;
  assign bus.ic_data = hit ? data_arr[idx][word] : '0;

endmodule

// File: tb/tb_dlx_icache.sv
module tb_dlx_icache;
  import dlx_global_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dlx_icache_if bus ();

  dlx_icache #(
    .NUM_LINES  (64),
    .LINE_WORDS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic    model_ack = 1'b0, spur_ack, model_flush = 1'b0, main_flush, flush_armed;
  dlx_word model_rdata = '0, spur_rdata;
  dlx_addr addr_log[$];

  assign bus.mem_ack   = model_ack | spur_ack;
  assign bus.mem_rdata = spur_ack ? spur_rdata : model_rdata;
  assign bus.ic_flush  = main_flush | model_flush;

  // Memory contents: word k of line at (a>>4) holds (k+1)*0x11 + (a>>4)*0x100.
  function automatic dlx_word mem_word(dlx_addr a);
    dlx_addr sel;
    sel = a;
    return ((32'(sel[3:2]) + 32'd1) * 32'h11) + ((sel >> 4) * 32'h100);
  endfunction

  // Memory responder: acks every cycle in which a request is present.
  always @(negedge clk) begin
    model_ack   = 1'b0;
    model_flush = 1'b0;
    if (rst_n && bus.mem_req) begin
      model_ack   = 1'b1;
      model_rdata = mem_word(bus.mem_addr);
      addr_log.push_back(bus.mem_addr);
      if (flush_armed && bus.mem_addr[3:2] == 2'b11) model_flush = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_hit(input int limit, output int n);
    n = 0;
    while (bus.ic_wait && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    if (bus.ic_wait) check("hit_timeout", 32'(bus.ic_wait), 32'd0);
  endtask

  task automatic wait_log(input int k, input int limit);
    int n;
    n = 0;
    while (addr_log.size() < k && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    if (addr_log.size() < k) check("ack_timeout", 32'(addr_log.size()), 32'(k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    rst_n = 1'b0; bus.ic_addr = '0; main_flush = 1'b0;
    spur_ack = 1'b0; spur_rdata = '0; flush_armed = 1'b0;

    // Reset state
    repeat (3) @(negedge clk); #1;
    check("rst_wait", 32'(bus.ic_wait), 32'd1);
    check("rst_data", bus.ic_data, 32'h0);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_maddr", bus.mem_addr, 32'h0);

    // First miss and refill of line 0
    @(negedge clk); rst_n = 1'b1; base = addr_log.size(); #1;
    check("miss_wait", 32'(bus.ic_wait), 32'd1);
    @(negedge clk); #1;
    check("req_issued", 32'(bus.mem_req), 32'd1);
    check("req_addr", bus.mem_addr, 32'h0);
    wait_hit(20, n);
    check("miss_latency", 32'(n + 1), 32'd5);
    check("fill0_data", bus.ic_data, 32'h11);
    for (int i = 0; i < 4; i++) check("fill0_addr", addr_log[base + i], 32'(i * 4));

    // Same-cycle hits on the other words
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); bus.ic_addr = 32'(i * 4); #1;
      check("hit_wait", 32'(bus.ic_wait), 32'd0);
      check("hit_data", bus.ic_data, 32'(32'h11 * (i + 1)));
    end

    // Stray ack while idle
    @(negedge clk); bus.ic_addr = 32'h0; spur_ack = 1'b1; spur_rdata = 32'hDEADBEEF; #1;
    check("idle_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk); spur_ack = 1'b0; #1;
    check("stray_ack_data", bus.ic_data, 32'h11);

    // Conflict on index 0
    @(negedge clk); base = addr_log.size(); bus.ic_addr = 32'h400; #1;
    check("conflict_wait", 32'(bus.ic_wait), 32'd1);
    wait_hit(20, n);
    check("conflict_data", bus.ic_data, 32'h4011);
    check("conflict_addr0", addr_log[base], 32'h400);
    check("conflict_addr3", addr_log[base + 3], 32'h40C);
    @(negedge clk); bus.ic_addr = 32'h0; #1;
    check("evicted_miss", 32'(bus.ic_wait), 32'd1);
    wait_hit(20, n);
    check("refetch_data", bus.ic_data, 32'h11);

    // Flush pulse while line 0 is valid
    @(negedge clk); main_flush = 1'b1; #1;
    check("flush_same_cycle", 32'(bus.ic_wait), 32'd0);
    @(negedge clk); main_flush = 1'b0; base = addr_log.size(); #1;
    check("flush_miss", 32'(bus.ic_wait), 32'd1);

    // Address change during refill
    wait_log(base + 1, 20);
    bus.ic_addr = 32'h20; #1;
    check("midrefill_wait", 32'(bus.ic_wait), 32'd1);
    wait_hit(40, n);
    check("midrefill_data", bus.ic_data, 32'h211);
    for (int i = 1; i < 4; i++) check("midrefill_old", addr_log[base + i], 32'(i * 4));
    for (int i = 0; i < 4; i++) check("midrefill_new", addr_log[base + 4 + i], 32'(32'h20 + i * 4));
    @(negedge clk); bus.ic_addr = 32'h0; #1;
    check("old_line_kept", bus.ic_data, 32'h11);

    // Flush coincident with the final ack
    @(negedge clk); flush_armed = 1'b1; base = addr_log.size(); bus.ic_addr = 32'h400; #1;
    wait_log(base + 4, 20);
    @(negedge clk); #1;
    flush_armed = 1'b0;
    check("flush_wins", 32'(bus.ic_wait), 32'd1);
    check("req_drop_after_last", 32'(bus.mem_req), 32'd0);
    wait_hit(20, n);
    check("flush_wins_refetch", addr_log[base + 4], 32'h400);
    check("flush_wins_data", bus.ic_data, 32'h4013 - 32'h2);

    // Flush earlier in a refill: line still validated
    @(negedge clk); base = addr_log.size(); bus.ic_addr = 32'h20; #1;
    check("early_miss", 32'(bus.ic_wait), 32'd1);
    wait_log(base + 2, 20);
    main_flush = 1'b1;
    @(negedge clk); main_flush = 1'b0; #1;
    wait_hit(20, n);
    check("early_flush_valid", bus.ic_data, 32'h211);
    @(negedge clk); bus.ic_addr = 32'h400; #1;
    check("early_flush_cleared", 32'(bus.ic_wait), 32'd1);
    wait_hit(20, n);

    // Reset during second refill word
    @(negedge clk); main_flush = 1'b1;
    @(negedge clk); main_flush = 1'b0; bus.ic_addr = 32'h0; base = addr_log.size(); #1;
    check("pre_rst_miss", 32'(bus.ic_wait), 32'd1);
    wait_log(base + 2, 20);
    rst_n = 1'b0; #1;
    check("async_req", 32'(bus.mem_req), 32'd0);
    check("async_maddr", bus.mem_addr, 32'h0);
    check("async_wait", 32'(bus.ic_wait), 32'd1);
    check("async_data", bus.ic_data, 32'h0);
    @(negedge clk); rst_n = 1'b1; base = addr_log.size(); #1;
    check("post_rst_miss", 32'(bus.ic_wait), 32'd1);
    wait_log(base + 1, 20);
    check("restart_word0", addr_log[base], 32'h0);
    wait_hit(20, n);
    check("restart_data", bus.ic_data, 32'h11);
    @(negedge clk); bus.ic_addr = 32'h20; #1;
    check("post_rst_other_miss", 32'(bus.ic_wait), 32'd1);
    wait_hit(20, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
